// File: rtl/rgen_host_if_apb_ex.sv
// APB slave front end that turns APB transfers into the register block's command/response
// handshake, with strobe-to-bit-mask expansion and an optional response timeout.
// Optional build macro: RGEN_APB_PROT_CHECK_EN (reject unprivileged accesses with PSLVERR).
module rgen_host_if_apb_ex #(
    parameter int DATA_WIDTH          = 32,
    parameter int HOST_ADDRESS_WIDTH  = 16,
    parameter int LOCAL_ADDRESS_WIDTH = 8,
    parameter int TIMEOUT_CYCLES      = 0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [HOST_ADDRESS_WIDTH-1:0]  i_paddr,
    input  logic [2:0]                     i_pprot,
    input  logic                           i_psel,
    input  logic                           i_penable,
    input  logic                           i_pwrite,
    input  logic [DATA_WIDTH-1:0]          i_pwdata,
    input  logic [DATA_WIDTH/8-1:0]        i_pstrb,
    output logic                           o_pready,
    output logic [DATA_WIDTH-1:0]          o_prdata,
    output logic                           o_pslverr,
    output logic                           o_command_valid,
    output logic                           o_write,
    output logic                           o_read,
    output logic [LOCAL_ADDRESS_WIDTH-1:0] o_address,
    output logic [DATA_WIDTH-1:0]          o_write_data,
    output logic [DATA_WIDTH-1:0]          o_write_mask,
    input  logic                           i_response_ready,
    input  logic [DATA_WIDTH-1:0]          i_read_data,
    input  logic [1:0]                     i_status
);

    localparam int STRB_WIDTH    = DATA_WIDTH / 8;
    localparam int ALIGN_BITS    = $clog2(STRB_WIDTH);
    localparam logic [LOCAL_ADDRESS_WIDTH-1:0] ALIGN_MASK =
        LOCAL_ADDRESS_WIDTH'((1 << ALIGN_BITS) - 1);
    localparam bit TIMEOUT_EN    = (TIMEOUT_CYCLES > 0);
    localparam int TIMEOUT_WIDTH = TIMEOUT_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_LAST =
        TIMEOUT_EN ? TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RESPOND = 2'd2
    } state_t;

    state_t                           r_state;
    logic                             r_pready;
    logic [DATA_WIDTH-1:0]            r_prdata;
    logic                             r_pslverr;
    logic                             r_command_valid;
    logic                             r_write;
    logic                             r_read;
    logic [LOCAL_ADDRESS_WIDTH-1:0]   r_address;
    logic [DATA_WIDTH-1:0]            r_write_data;
    logic [DATA_WIDTH-1:0]            r_write_mask;
    logic [TIMEOUT_WIDTH-1:0]         r_timeout_count;

    logic [DATA_WIDTH-1:0]            w_write_mask;
    logic [LOCAL_ADDRESS_WIDTH-1:0]   w_address;
    logic                             w_setup;
    logic                             w_timeout_expired;
    logic                             w_prot_reject;
    logic                             w_unused;

    assign w_setup   = i_psel & ~i_penable;
    assign w_address = i_paddr[LOCAL_ADDRESS_WIDTH-1:0] & ~ALIGN_MASK;

    // Protection bits and upper host address bits are intentionally not decoded.
    assign w_unused  = ^{i_pprot, i_paddr};

`ifdef RGEN_APB_PROT_CHECK_EN
    assign w_prot_reject = ~i_pprot[0];
`else
    assign w_prot_reject = 1'b0;
`endif

    // Byte strobes expand to a per-bit write enable; reads enable every bit.
    always_comb begin
        w_write_mask = '0;
        if (i_pwrite) begin
            for (int k = 0; k < STRB_WIDTH; k++) begin
                w_write_mask[8*k +: 8] = {8{i_pstrb[k]}};
            end
        end else begin
            w_write_mask = '1;
        end
    end

    // Expiry fires on the last permitted BUSY cycle that still has no response.
    always_comb begin
        w_timeout_expired = 1'b0;
        if (TIMEOUT_EN) begin
            w_timeout_expired = (r_timeout_count == TIMEOUT_LAST);
        end else begin
            w_timeout_expired = 1'b0;
        end
    end

    // Transfer FSM owning every registered output and the timeout counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state         <= ST_IDLE;
            r_pready        <= 1'b0;
            r_prdata        <= '0;
            r_pslverr       <= 1'b0;
            r_command_valid <= 1'b0;
            r_write         <= 1'b0;
            r_read          <= 1'b0;
            r_address       <= '0;
            r_write_data    <= '0;
            r_write_mask    <= '0;
            r_timeout_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_pready  <= 1'b0;
                    r_prdata  <= '0;
                    r_pslverr <= 1'b0;
                    if (w_setup && w_prot_reject) begin
                        r_pready  <= 1'b1;
                        r_pslverr <= 1'b1;
                        r_state   <= ST_RESPOND;
                    end else if (w_setup) begin
                        r_command_valid <= 1'b1;
                        r_write         <= i_pwrite;
                        r_read          <= ~i_pwrite;
                        r_address       <= w_address;
                        r_write_data    <= i_pwdata;
                        r_write_mask    <= w_write_mask;
                        r_timeout_count <= '0;
                        r_state         <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    // A response arriving in the expiry cycle takes priority.
                    if (i_response_ready) begin
                        r_prdata        <= r_read ? i_read_data : '0;
                        r_pslverr       <= (i_status != 2'd0);
                        r_pready        <= 1'b1;
                        r_command_valid <= 1'b0;
                        r_write         <= 1'b0;
                        r_read          <= 1'b0;
                        r_state         <= ST_RESPOND;
                    end else if (w_timeout_expired) begin
                        r_prdata        <= '0;
                        r_pslverr       <= 1'b1;
                        r_pready        <= 1'b1;
                        r_command_valid <= 1'b0;
                        r_write         <= 1'b0;
                        r_read          <= 1'b0;
                        r_state         <= ST_RESPOND;
                    end else if (TIMEOUT_EN) begin
                        r_timeout_count <= r_timeout_count + TIMEOUT_WIDTH'(1);
                    end
                end
                ST_RESPOND: begin
                    r_pready  <= 1'b0;
                    r_prdata  <= '0;
                    r_pslverr <= 1'b0;
                    r_state   <= ST_IDLE;
                end
                default: begin
                    r_state         <= ST_IDLE;
                    r_pready        <= 1'b0;
                    r_prdata        <= '0;
                    r_pslverr       <= 1'b0;
                    r_command_valid <= 1'b0;
                    r_write         <= 1'b0;
                    r_read          <= 1'b0;
                end
            endcase
        end
    end

    assign o_pready        = r_pready;
    assign o_prdata        = r_prdata;
    assign o_pslverr       = r_pslverr;
    assign o_command_valid = r_command_valid;
    assign o_write         = r_write;
    assign o_read          = r_read;
    assign o_address       = r_address;
    assign o_write_data    = r_write_data;
    assign o_write_mask    = r_write_mask;

endmodule
